seq_muldiv: RTL and testbench
=============================

Name: seq_muldiv

Overview:
Parametrised sequential unsigned multiplier/divider. It generalises the combinational N-bit multiplier into a multi-cycle shift-add multiplier and restoring divider that share one datapath. A START/BUSY/DONE handshake lets a controller or testbench issue one operation at a time. Intended for datapath blocks that need N-bit multiply and divide without a full combinational array.

Parameters:
N, 4, operand width in bits (N >= 2); result width is 2*N

Ports:
CLK  input  1  system clock, rising-edge active
N_RESET  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE
OP  input  1  0 = multiply, 1 = divide; sampled with START
A  input  N  multiplicand / dividend; sampled with START
B  input  N  multiplier / divisor; sampled with START
BUSY  output  1  high from the accepting edge until the edge that leaves DONE
DONE  output  1  one-cycle pulse; Y and DIV0 are valid
Y  output  2N  mul: product; div: {remainder[N-1:0], quotient[N-1:0]}
DIV0  output  1  divide with B == 0; valid with DONE, held with Y

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on N_RESET.
- Reset values:
  - State = IDLE.
  - BUSY = 0, DONE = 0, DIV0 = 0, Y = 0.
  - Internal accumulator, operand registers and counter are all 0.
- States:
  - IDLE -> RUN on a rising edge with START = 1. At that edge the block latches OP, A and B, loads the counter with N, and sets BUSY.
  - RUN: one iteration per edge; the counter decrements. On the edge where the counter goes from 1 to 0, the block writes Y and DIV0 and moves to DONE.
  - DONE: DONE = 1 for exactly one cycle, then IDLE on the next edge and BUSY clears.
- Latency:
  - START accepted at edge t0; DONE is high in the cycle after edge t0+N.
  - Back-to-back issue is possible every N+2 cycles.
- Multiply (shift-add, LSB first):
  - Each iteration: if the multiplier LSB is 1, add the multiplicand into the upper N+1 bits of the accumulator, then shift right by 1.
  - Final Y = A*B exactly, with no overflow because the result is 2N bits.
- Divide (restoring):
  - Each iteration: shift {R,Q} left; trial-subtract B from R (N+1 bits). If the result is non-negative, keep it and set Q[0] = 1; otherwise restore R.
  - Final result: Q = A / B, R = A % B.
- Divide by zero (B == 0):
  - No special-case datapath; the natural result is quotient all ones and remainder A.
  - Y = {A, {N{1'b1}}}, DIV0 = 1.
  - For multiply, or for divide with B != 0, DIV0 = 0.
- Y and DIV0 hold their last values until the next operation completes. Y is not cleared by START.
- START while BUSY (RUN or DONE) is ignored, with no queuing. Operand or OP changes during RUN have no effect.
- START held high continuously: a new operation is accepted on the first edge back in IDLE.
- Reset asserted mid-operation: all outputs return immediately to their reset values and the result is discarded. After release the block idles until a new START.

Optional Feature:
Macro MULDIV_SIGNED_EN.
- Defined:
  - Adds input port SGN (1 bit), sampled with START.
  - SGN = 1 treats A and B as two's complement. Operands are converted to magnitudes at accept; at the final RUN edge the product, or the quotient and remainder, are negated. Product sign = sign(A) XOR sign(B). Quotient sign is the same. Remainder takes the sign of A.
  - Latency is unchanged.
  - Divide by zero returns Y = {A, {N{1'b1}}} raw and DIV0 = 1.
  - SGN = 0 behaves exactly as the undefined build.
- Undefined: there is no SGN port and all arithmetic is unsigned.

Test Plan:
1. Reset, then MUL A=0, B=0 -> DONE 4 cycles after accept edge, Y=8'd0, DIV0=0, BUSY high for 5 cycles.
2. MUL A=15, B=15 -> Y=8'd225. Then MUL A=13, B=11 -> Y=8'd143.
3. DIV A=13, B=4 -> Y=8'h13 (R=1, Q=3), DIV0=0. Then DIV A=15, B=1 -> Y=8'h0F.
4. DIV A=9, B=0 -> Y=8'h9F, DIV0=1. Then MUL A=2, B=3 -> Y=8'd6, DIV0 cleared to 0.
5. MUL A=7, B=7; pulse START with A=1, B=1 during RUN -> ignored, Y=8'd49. Then assert N_RESET low two edges into a new op -> BUSY=0, DONE=0, Y=0 immediately, no DONE pulse afterwards.
6. (MULDIV_SIGNED_EN, SGN=1)
   - MUL A=4'hD (-3), B=5 -> Y=8'hF1 (-15).
   - DIV A=4'hB (-5), B=2 -> Q=4'hE (-2), R=4'hF (-1), Y=8'hFE.

Source files
------------

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - multi-cycle shift-add multiplier / restoring divider sharing one datapath
// Optional build macro MULDIV_SIGNED_EN adds the SGN port for two's-complement operands.
module seq_muldiv #(
    parameter int N = 4
) (
    input  logic           CLK,
    input  logic           N_RESET,
    input  logic           START,
    input  logic           OP,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
`ifdef MULDIV_SIGNED_EN
    input  logic           SGN,
`endif
    output logic           BUSY,
    output logic           DONE,
    output logic [2*N-1:0] Y,
    output logic           DIV0
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    // Accumulator: multiply keeps {partial product hi (N+1), multiplier (N)};
    // divide keeps {partial remainder (N+1), quotient/dividend (N)}.
    logic [2*N:0]   r_acc;
    logic [N-1:0]   r_b;
    logic           r_op;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_y;
    logic           r_div0;

    logic           w_accept;
    logic           w_last;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic [N:0]     w_mul_hi;
    logic [2*N:0]   w_shl;
    logic [N+1:0]   w_trial;
    logic [2*N:0]   w_acc_step;
    logic [2*N-1:0] w_y_fin;
    logic           w_div0_fin;

`ifdef MULDIV_SIGNED_EN
    logic           r_neg_q;
    logic           r_neg_r;
    logic [N-1:0]   r_a_raw;
    logic           w_neg_q;
    logic           w_neg_r;
    logic [N-1:0]   w_q_mag;
    logic [N-1:0]   w_r_mag;
`endif

    assign w_accept = (r_state == S_IDLE) && START;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

    // Operand magnitudes loaded at accept; signed mode strips the sign here
    always_comb begin
        w_a_mag = A;
        w_b_mag = B;
`ifdef MULDIV_SIGNED_EN
        w_neg_q = 1'b0;
        w_neg_r = 1'b0;
        if (SGN) begin
            if (A[N-1]) w_a_mag = ~A + 1'b1;
            if (B[N-1]) w_b_mag = ~B + 1'b1;
            w_neg_q = A[N-1] ^ B[N-1];
            w_neg_r = A[N-1];
        end
`endif
    end

    // One multiply or divide iteration on the shared accumulator
    always_comb begin
        w_mul_hi = r_acc[2*N:N] + (r_acc[0] ? {1'b0, r_b} : '0);
        w_shl    = {r_acc[2*N-1:0], 1'b0};
        w_trial  = {1'b0, w_shl[2*N:N]} - {2'b00, r_b};
        if (!r_op)
            w_acc_step = {1'b0, w_mul_hi, r_acc[N-1:1]};
        else if (!w_trial[N+1])
            w_acc_step = {w_trial[N:0], w_shl[N-1:1], 1'b1};
        else
            w_acc_step = w_shl;
    end

    // Result formed from the last iteration, with sign fix-up in signed mode
    always_comb begin
        w_div0_fin = r_op && (r_b == '0);
        w_y_fin    = w_acc_step[2*N-1:0];
`ifdef MULDIV_SIGNED_EN
        w_q_mag = w_acc_step[N-1:0];
        w_r_mag = w_acc_step[2*N-1:N];
        if (w_div0_fin) begin
            // Divide by zero reports the raw dividend, not its magnitude
            w_y_fin = {r_a_raw, {N{1'b1}}};
        end else if (!r_op) begin
            if (r_neg_q) w_y_fin = ~w_acc_step[2*N-1:0] + 1'b1;
        end else begin
            w_y_fin = {(r_neg_r ? ~w_r_mag + 1'b1 : w_r_mag),
                       (r_neg_q ? ~w_q_mag + 1'b1 : w_q_mag)};
        end
`endif
    end

    // State register
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: IDLE -> RUN on START, RUN for N edges, DONE for one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (START)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        BUSY = (r_state != S_IDLE);
        DONE = (r_state == S_DONE);
    end

    // Datapath: latch operands at accept, iterate in RUN, capture result on the final edge
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_acc  <= '0;
            r_b    <= '0;
            r_op   <= 1'b0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_div0 <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_a_raw <= '0;
`endif
        end else if (w_accept) begin
            r_acc <= {{(N+1){1'b0}}, w_a_mag};
            r_b   <= w_b_mag;
            r_op  <= OP;
            r_cnt <= CW'(N);
`ifdef MULDIV_SIGNED_EN
            r_neg_q <= w_neg_q;
            r_neg_r <= w_neg_r;
            r_a_raw <= A;
`endif
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_y    <= w_y_fin;
                r_div0 <= w_div0_fin;
            end
        end
    end

    assign Y    = r_y;
    assign DIV0 = r_div0;

endmodule

// File: tb/tb_seq_muldiv.sv
// tb/tb_seq_muldiv.sv - self-checking bench for seq_muldiv (vectors, corner sequences, random vs model)
module tb_seq_muldiv;

    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           N_RESET = 1'b0;
    logic           START = 1'b0;
    logic           OP = 1'b0;
    logic [N-1:0]   A = '0;
    logic [N-1:0]   B = '0;
`ifdef MULDIV_SIGNED_EN
    logic           SGN = 1'b0;
`endif
    logic           BUSY;
    logic           DONE;
    logic [2*N-1:0] Y;
    logic           DIV0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_muldiv #(.N(N)) dut (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .START   (START),
        .OP      (OP),
        .A       (A),
        .B       (B),
`ifdef MULDIV_SIGNED_EN
        .SGN     (SGN),
`endif
        .BUSY    (BUSY),
        .DONE    (DONE),
        .Y       (Y),
        .DIV0    (DIV0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic           op;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           sgn;
        logic [2*N-1:0] y;
        logic           div0;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic logic [2*N-1:0] ref_y(input logic op, input logic [N-1:0] a,
                                             input logic [N-1:0] b, input logic sgn);
        logic signed [31:0] sa, sb, sres, sq, sr;
        logic [31:0] ua, ub, ures, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = 32'(a);
        ub = 32'(b);
        if (!op) begin
            if (sgn) begin
                sres = sa * sb;
                return sres[2*N-1:0];
            end
            ures = ua * ub;
            return ures[2*N-1:0];
        end
        if (b == '0) return {a, {N{1'b1}}};
        if (sgn) begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr[N-1:0], sq[N-1:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[N-1:0], uq[N-1:0]};
    endfunction

    task automatic run_op(input string name, input logic op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic sgn,
                          input logic [2*N-1:0] exp_y, input logic exp_div0);
        int cyc;
        @(negedge CLK);
        START = 1'b1; OP = op; A = a; B = b;
`ifdef MULDIV_SIGNED_EN
        SGN = sgn;
`endif
        @(negedge CLK);
        START = 1'b0;
        check({name, " busy_after_accept"}, 64'(BUSY), 64'd1);
        cyc = 0;
        while (!DONE && cyc < 3*N) begin
            @(negedge CLK);
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(N));
        check({name, " y"}, 64'(Y), 64'(exp_y));
        check({name, " div0"}, 64'(DIV0), 64'(exp_div0));
        check({name, " busy_in_done"}, 64'(BUSY), 64'd1);
        @(negedge CLK);
        check({name, " done_one_cycle"}, 64'(DONE), 64'd0);
        check({name, " busy_cleared"}, 64'(BUSY), 64'd0);
    endtask

    initial begin
        vec_t vecs[7];
        int cyc;
        int ndone;
        logic s;
        logic o;
        logic [N-1:0] ra, rb;

        vecs[0] = '{1'b0, 4'd0,  4'd0,  1'b0, 8'd0,   1'b0};
        vecs[1] = '{1'b0, 4'd15, 4'd15, 1'b0, 8'd225, 1'b0};
        vecs[2] = '{1'b0, 4'd13, 4'd11, 1'b0, 8'd143, 1'b0};
        vecs[3] = '{1'b1, 4'd13, 4'd4,  1'b0, 8'h13,  1'b0};
        vecs[4] = '{1'b1, 4'd15, 4'd1,  1'b0, 8'h0F,  1'b0};
        vecs[5] = '{1'b1, 4'd9,  4'd0,  1'b0, 8'h9F,  1'b1};
        vecs[6] = '{1'b0, 4'd2,  4'd3,  1'b0, 8'd6,   1'b0};

        repeat (2) @(negedge CLK);
        check("reset busy", 64'(BUSY), 64'd0);
        check("reset done", 64'(DONE), 64'd0);
        check("reset y", 64'(Y), 64'd0);
        check("reset div0", 64'(DIV0), 64'd0);
        N_RESET = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sgn,
                   vecs[i].y, vecs[i].div0);

        // START during RUN is ignored; Y holds the previous result until completion
        @(negedge CLK);
        START = 1'b1; OP = 1'b0; A = 4'd7; B = 4'd7;
        @(negedge CLK);
        START = 1'b0;
        check("hold y during run", 64'(Y), 64'd6);
        START = 1'b1; OP = 1'b1; A = 4'd1; B = 4'd1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 1;
        while (!DONE && cyc < 3*N) begin
            @(negedge CLK);
            cyc++;
        end
        check("ignore latency", 64'(cyc), 64'(N));
        check("ignore y", 64'(Y), 64'd49);
        check("ignore div0", 64'(DIV0), 64'd0);
        @(negedge CLK);
        check("ignore no retrigger", 64'(BUSY), 64'd0);

        // Asynchronous reset two edges into an operation
        @(negedge CLK);
        START = 1'b1; OP = 1'b1; A = 4'd13; B = 4'd4;
        @(posedge CLK);
        #1 START = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2 N_RESET = 1'b0;
        #1;
        check("midreset busy", 64'(BUSY), 64'd0);
        check("midreset done", 64'(DONE), 64'd0);
        check("midreset y", 64'(Y), 64'd0);
        check("midreset div0", 64'(DIV0), 64'd0);
        @(negedge CLK);
        N_RESET = 1'b1;
        ndone = 0;
        for (int i = 0; i < 3*N; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) ndone++;
        end
        check("midreset stays idle", 64'(ndone), 64'd0);

        // START held high: back-to-back issue every N+2 cycles
        @(negedge CLK);
        START = 1'b1; OP = 1'b0; A = 4'd3; B = 4'd5;
        cyc = 0;
        while (!DONE && cyc < 4*N) begin
            @(negedge CLK);
            cyc++;
        end
        check("held first done", 64'(DONE), 64'd1);
        check("held first y", 64'(Y), 64'd15);
        A = 4'd4;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!DONE && cyc < 4*N);
        check("held period", 64'(cyc), 64'(N + 2));
        check("held second y", 64'(Y), 64'd20);
        START = 1'b0;
        repeat (2) @(negedge CLK);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            o  = 1'($urandom_range(0, 1));
            ra = N'($urandom);
            rb = (i % 8 == 0) ? '0 : N'($urandom);
            s  = 1'b0;
`ifdef MULDIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`endif
            run_op($sformatf("rnd%0d op%0d a%0h b%0h s%0d", i, o, ra, rb, s), o, ra, rb, s,
                   ref_y(o, ra, rb, s), o && (rb == '0));
        end

`ifdef MULDIV_SIGNED_EN
        run_op("smul -3*5", 1'b0, 4'hD, 4'd5, 1'b1, 8'hF1, 1'b0);
        run_op("sdiv -5/2", 1'b1, 4'hB, 4'd2, 1'b1, 8'hFE, 1'b0);
        run_op("sdiv -3/0", 1'b1, 4'hD, 4'd0, 1'b1, 8'hDF, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
